mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
//
// PURPOSE
//   Shares the single-port unified instruction/data memory between two requesters:
//   - instruction fetch port (I, read-only)
//   - load/store data port (D, read/write)
//   Sits between the multi-cycle core and the memory.
//   Arbitrates round-robin, runs one memory access per grant, and returns registered
//   read data with a one-cycle acknowledge pulse.
//   Memory read is combinational and addressed by word (address[31:2]); memory write is
//   synchronous on the rising edge of clk.
//
// PARAMETERS
//   ADDR_WIDTH  32  width of the byte address on all ports
//   DATA_WIDTH  32  width of the data word on all ports
//
// PORTS
//   clk             in   1           clock, rising edge
//   reset           in   1           synchronous, active-high reset
//   i_req           in   1           instruction fetch request; held high until i_ack
//   i_addr          in   ADDR_WIDTH  fetch byte address; stable while i_req is high
//   i_ack           out  1           one-cycle pulse: fetch complete, i_rdata valid
//   i_rdata         out  DATA_WIDTH  fetched word; holds its value until the next I grant
//   d_req           in   1           data request; held high until d_ack
//   d_we            in   1           1 = store, 0 = load; stable while d_req is high
//   d_addr          in   ADDR_WIDTH  data byte address; stable while d_req is high
//   d_wdata         in   DATA_WIDTH  store data; stable while d_req is high
//   d_ack           out  1           one-cycle pulse: access complete, d_rdata valid for a load
//   d_rdata         out  DATA_WIDTH  loaded word; holds its value until the next D load
//   mem_address     out  ADDR_WIDTH  byte address to the memory
//   mem_write_data  out  DATA_WIDTH  write data to the memory
//   mem_write       out  1           memory write enable
//   mem_read_data   in   DATA_WIDTH  combinational read data from the memory
//
// BEHAVIOUR
//   Reset values (all registered):
//   - state = IDLE; i_ack = d_ack = 0; i_rdata = d_rdata = 0
//   - latched addr/wdata/we = 0; last_grant = D, so I wins the first tie
//   State machine:
//   - IDLE
//     - No request: stay in IDLE.
//     - Exactly one request: grant it.
//     - Both requests: grant the port not equal to last_grant.
//     - On grant: latch owner, address, write data and we (forced to 0 for I);
//       update last_grant; go to ACCESS.
//   - ACCESS
//     - mem_address = latched address; mem_write_data = latched write data.
//     - mem_write = latched we & (owner == D) & ~reset.
//     - For a read: capture mem_read_data into i_rdata or d_rdata at the clock edge.
//     - Go to RESP.
//   - RESP
//     - Assert the owner's ack for exactly this one cycle; go to IDLE.
//     - Requests are not sampled in RESP.
//   Outputs outside ACCESS:
//   - mem_write = 0.
//   - mem_address and mem_write_data keep driving the latched values (no combinational
//     path from the input ports).
//   Latency and throughput:
//   - Request seen in IDLE at cycle N: memory driven at N+1, ack at N+2.
//   - Peak rate is one access per 3 cycles.
//   Handshake rules:
//   - The requester drops req in the cycle after ack.
//   - If req is still high in the next IDLE cycle, it is a new request.
//   - Address and data changes while req is high are not supported; only the values
//     latched at grant are used.
//   Fairness:
//   - Both ports held high alternate strictly: I, D, I, D, ...
//   - A lone requester is served back-to-back, regardless of last_grant.
//   Addresses:
//   - Passed through unmodified; address[1:0] is ignored by the memory (word access).
//   - No alignment check is made.
//   Reset mid-operation:
//   - From any state, the next edge returns to IDLE with acks 0.
//   - mem_write is gated low during reset, so a store caught in ACCESS is not written.
//   - The pending request is dropped; the requester re-issues it after reset.
//   Simultaneous ack and new request: impossible by construction, since acks occur only
//   in RESP and grants only in IDLE.
//
// TESTING
//   1. Reset then i_req=1, i_addr=0x8, mem word[2]=0x12345678
//      -> i_ack=1 exactly at cycle 2 with i_rdata=0x12345678; mem_write stays 0 throughout.
//   2. d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF
//      -> mem_write=1 for one cycle (ACCESS) with mem_address=0x10; d_ack at cycle 2.
//      Then a load from 0x10 -> d_rdata=0xDEADBEEF.
//   3. After reset, i_req and d_req both rise together and are held
//      -> i_ack at cycles 2, 8, ...; d_ack at cycles 5, 11, ... (strict alternation).
//   4. Only i_req held continuously for 4 accesses
//      -> i_ack at cycles 2, 5, 8, 11; d_ack never asserted.
//   5. Store to 0x20 with reset asserted during the ACCESS cycle
//      -> mem_write=0 in that cycle; state IDLE and no d_ack after reset; word 0x20 unchanged.
//   6. Load 0x4 followed by a fetch of 0x4
//      -> d_rdata keeps the loaded value unchanged while i_rdata updates; each ack is
//      one cycle wide.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (I)
// and load/store (D) requesters; one access per grant, registered data, one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t                state_q,     state_d;
  port_t                 owner_q,     owner_d;
  port_t                 lastGrant_q, lastGrant_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                  we_q,        we_d;
  logic                  iAck_q,      iAck_d;
  logic                  dAck_q,      dAck_d;
  logic [DATA_WIDTH-1:0] iRdata_q,    iRdata_d;
  logic [DATA_WIDTH-1:0] dRdata_q,    dRdata_d;

  logic grantI;
  logic grantD;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grantI = i_req && (!d_req || (lastGrant_q == PORT_D));
    grantD = d_req && (!i_req || (lastGrant_q == PORT_I));
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    iAck_d      = 1'b0;
    dAck_d      = 1'b0;
    iRdata_d    = iRdata_q;
    dRdata_d    = dRdata_q;

    unique case (state_q)
      IDLE: begin
        if (grantI) begin
          owner_d     = PORT_I;
          lastGrant_d = PORT_I;
          addr_d      = i_addr;
          we_d        = 1'b0;
          state_d     = ACCESS;
        end else if (grantD) begin
          owner_d     = PORT_D;
          lastGrant_d = PORT_D;
          addr_d      = d_addr;
          wdata_d     = d_wdata;
          we_d        = d_we;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is captured here so it is already stable during the ack cycle.
        if (!we_q) begin
          if (owner_q == PORT_I) begin
            iRdata_d = mem_read_data;
          end else begin
            dRdata_d = mem_read_data;
          end
        end
        iAck_d  = (owner_q == PORT_I);
        dAck_d  = (owner_q == PORT_D);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= PORT_I;
      lastGrant_q <= PORT_D;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      iAck_q      <= 1'b0;
      dAck_q      <= 1'b0;
      iRdata_q    <= '0;
      dRdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      iAck_q      <= iAck_d;
      dAck_q      <= dAck_d;
      iRdata_q    <= iRdata_d;
      dRdata_q    <= dRdata_d;
    end
  end

  // Reset gates the write strobe so a store caught mid-access never lands.
  always_comb begin
    mem_address    = addr_q;
    mem_write_data = wdata_q;
    mem_write      = (state_q == ACCESS) && we_q && (owner_q == PORT_D) && !reset;
  end

  assign i_ack   = iAck_q;
  assign d_ack   = dAck_q;
  assign i_rdata = iRdata_q;
  assign d_rdata = dRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic        bdWe;
  logic [5:0]  bdAddr;
  logic [31:0] bdData;

  int assertCount;
  int failCount;

  logic [15:0] iAckH;
  logic [15:0] dAckH;
  logic [15:0] mwH;
  logic [31:0] mwAddr;
  logic [31:0] mwData;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_ack         (i_ack),
    .i_rdata       (i_rdata),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_ack         (d_ack),
    .d_rdata       (d_rdata),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: combinational read, write on the rising edge.
  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (bdWe) begin
      mem[bdAddr] <= bdData;
    end else if (mem_write) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [5:0] word, input logic [31:0] data);
    bdAddr = word;
    bdData = data;
    bdWe   = 1'b1;
    @(posedge clk);
    #1 bdWe = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs n cycles from the current one (cycle 0), recording acks and write strobes
  // sampled at each falling edge; non-held requesters drop req right after their ack.
  task automatic applyStimulus(input int n, input bit holdI, input bit holdD);
    iAckH  = '0;
    dAckH  = '0;
    mwH    = '0;
    mwAddr = '0;
    mwData = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      iAckH[c] = i_ack;
      dAckH[c] = d_ack;
      mwH[c]   = mem_write;
      if (mem_write) begin
        mwAddr = mem_address;
        mwData = mem_write_data;
      end
      @(posedge clk);
      #1;
      if (!holdI && iAckH[c]) i_req = 1'b0;
      if (!holdD && dAckH[c]) d_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    bdWe    = 1'b0;
    bdAddr  = '0;
    bdData  = '0;

    preload(6'd2, 32'h1234_5678);
    preload(6'd4, 32'h0000_0000);
    preload(6'd8, 32'hA5A5_A5A5);
    preload(6'd1, 32'hCAFE_F00D);
    applyReset();

    @(negedge clk);
    checkOutput("rst_i_ack",     {31'd0, i_ack},     32'd0);
    checkOutput("rst_d_ack",     {31'd0, d_ack},     32'd0);
    checkOutput("rst_i_rdata",   i_rdata,            32'd0);
    checkOutput("rst_d_rdata",   d_rdata,            32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_addr",  mem_address,        32'd0);
    @(posedge clk);
    #1;

    $display("[TB] fetch from 0x8");
    i_addr = 32'h8;
    i_req  = 1'b1;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("fetch_i_ack",  {16'd0, iAckH}, 32'h0004);
    checkOutput("fetch_d_ack",  {16'd0, dAckH}, 32'h0000);
    checkOutput("fetch_mw",     {16'd0, mwH},   32'h0000);
    checkOutput("fetch_rdata",  i_rdata,        32'h1234_5678);

    $display("[TB] store 0xDEADBEEF to 0x10 then load it back");
    d_addr  = 32'h10;
    d_wdata = 32'hDEAD_BEEF;
    d_we    = 1'b1;
    d_req   = 1'b1;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("store_mw",     {16'd0, mwH},   32'h0002);
    checkOutput("store_addr",   mwAddr,         32'h10);
    checkOutput("store_wdata",  mwData,         32'hDEAD_BEEF);
    checkOutput("store_d_ack",  {16'd0, dAckH}, 32'h0004);
    checkOutput("store_mem",    mem[4],         32'hDEAD_BEEF);
    d_we  = 1'b0;
    d_req = 1'b1;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("load_d_ack",   {16'd0, dAckH}, 32'h0004);
    checkOutput("load_mw",      {16'd0, mwH},   32'h0000);
    checkOutput("load_rdata",   d_rdata,        32'hDEAD_BEEF);

    $display("[TB] both requesters held after reset");
    applyReset();
    i_addr = 32'h8;
    d_addr = 32'h10;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    applyStimulus(12, 1'b1, 1'b1);
    checkOutput("alt_i_ack",    {16'd0, iAckH}, 32'h0104);
    checkOutput("alt_d_ack",    {16'd0, dAckH}, 32'h0820);
    checkOutput("alt_i_rdata",  i_rdata,        32'h1234_5678);
    checkOutput("alt_d_rdata",  d_rdata,        32'hDEAD_BEEF);

    $display("[TB] lone fetch requester held");
    applyReset();
    i_req = 1'b1;
    applyStimulus(12, 1'b1, 1'b0);
    checkOutput("lone_i_ack",   {16'd0, iAckH}, 32'h0924);
    checkOutput("lone_d_ack",   {16'd0, dAckH}, 32'h0000);

    $display("[TB] store to 0x20 interrupted by reset in ACCESS");
    applyReset();
    d_addr  = 32'h20;
    d_wdata = 32'h1111_1111;
    d_we    = 1'b1;
    d_req   = 1'b1;
    @(negedge clk);
    checkOutput("rststore_c0_ack", {31'd0, d_ack}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rststore_mw",     {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d_req = 1'b0;
    applyStimulus(3, 1'b0, 1'b0);
    checkOutput("rststore_d_ack",  {16'd0, dAckH}, 32'h0000);
    checkOutput("rststore_mw_post",{16'd0, mwH},   32'h0000);
    checkOutput("rststore_mem",    mem[8],         32'hA5A5_A5A5);
    d_we  = 1'b0;
    d_req = 1'b1;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("rststore_idle_ack", {16'd0, dAckH}, 32'h0004);
    checkOutput("rststore_rdata",    d_rdata,        32'hA5A5_A5A5);

    $display("[TB] load 0x4 then fetch 0x4 after memory change");
    d_addr = 32'h4;
    d_req  = 1'b1;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("ld4_d_ack",   {16'd0, dAckH}, 32'h0004);
    checkOutput("ld4_rdata",   d_rdata,        32'hCAFE_F00D);
    preload(6'd1, 32'h0BAD_F00D);
    i_addr = 32'h4;
    i_req  = 1'b1;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("f4_i_ack",    {16'd0, iAckH}, 32'h0004);
    checkOutput("f4_d_ack",    {16'd0, dAckH}, 32'h0000);
    checkOutput("f4_i_rdata",  i_rdata,        32'h0BAD_F00D);
    checkOutput("f4_d_rdata",  d_rdata,        32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
